// File: rtl/twos_to_signmag_norm.sv
// Two's-complement to sign/magnitude conversion with iterative left normalization.
// Latency: 2 + shifts edges, accept edge included. One word in flight; in_ready low until the result is taken.
module twos_to_signmag_norm #(
    parameter int W  = 49,
    parameter int EW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic [EW-1:0] in_exp,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sign,
    output logic [W-1:0]  out_mag,
    output logic [EW-1:0] out_exp,
    output logic          out_zero,
    output logic          out_denorm
);

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    localparam logic [W-1:0]  MAG_ONE = W'(1);
    localparam logic [EW-1:0] EXP_ONE = EW'(1);

    state_t        state_q;
    logic          sign_q;
    logic [W-1:0]  mag_q;
    logic [EW-1:0] exp_q;
    logic          zero_q;
    logic          denorm_q;
    logic [W-1:0]  in_abs;

    // The most negative value negates to itself, which is already the correct magnitude.
    assign in_abs = in_data[W-1] ? (~in_data + MAG_ONE) : in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            mag_q    <= '0;
            exp_q    <= '0;
            zero_q   <= 1'b0;
            denorm_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sign_q   <= in_data[W-1];
                        mag_q    <= in_abs;
                        exp_q    <= in_exp;
                        zero_q   <= 1'b0;
                        denorm_q <= 1'b0;
                        state_q  <= NORM;
                    end
                end
                NORM: begin
                    if (mag_q == '0) begin
                        zero_q  <= 1'b1;
                        sign_q  <= 1'b0;
                        exp_q   <= '0;
                        state_q <= DONE;
                    end else if (mag_q[W-1]) begin
                        state_q <= DONE;
                    end else if (exp_q == '0) begin
                        denorm_q <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        mag_q <= {mag_q[W-2:0], 1'b0};
                        exp_q <= exp_q - EXP_ONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_sign   = sign_q;
    assign out_mag    = mag_q;
    assign out_exp    = exp_q;
    assign out_zero   = zero_q;
    assign out_denorm = denorm_q;

endmodule

// File: tb/tb_twos_to_signmag_norm.sv
// Directed bench for twos_to_signmag_norm: hand-computed vectors, latency, backpressure and reset.
module tb_twos_to_signmag_norm;

    localparam int W  = 49;
    localparam int EW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [EW-1:0] in_exp;
    logic          out_valid;
    logic          out_ready;
    logic          out_sign;
    logic [W-1:0]  out_mag;
    logic [EW-1:0] out_exp;
    logic          out_zero;
    logic          out_denorm;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;

    always #5 clk = ~clk;

    twos_to_signmag_norm #(.W(W), .EW(EW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_exp     (in_exp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sign   (out_sign),
        .out_mag    (out_mag),
        .out_exp    (out_exp),
        .out_zero   (out_zero),
        .out_denorm (out_denorm)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Drives one word, then counts edges (accept edge = 1) until out_valid rises.
    task automatic send(input logic [W-1:0] d, input logic [EW-1:0] e, output int latency);
        @(negedge clk);
        check_eq("in_ready_before_send", {63'b0, in_ready}, 64'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_exp   = e;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = ~d;
        in_exp   = ~e;
        latency  = 1;
        while (!out_valid && latency < 200) begin
            @(posedge clk);
            #1;
            latency++;
        end
    endtask

    task automatic check_result(input string tag, input logic sgn, input logic [W-1:0] mag,
                                input logic [EW-1:0] ex, input logic zr, input logic dn,
                                input int lat_got, input int lat_exp);
        check_eq({tag, "_latency"}, 64'(lat_got), 64'(lat_exp));
        check_eq({tag, "_valid"},   {63'b0, out_valid}, 64'd1);
        check_eq({tag, "_sign"},    {63'b0, out_sign}, {63'b0, sgn});
        check_eq({tag, "_mag"},     64'(out_mag), 64'(mag));
        check_eq({tag, "_exp"},     64'(out_exp), 64'(ex));
        check_eq({tag, "_zero"},    {63'b0, out_zero}, {63'b0, zr});
        check_eq({tag, "_denorm"},  {63'b0, out_denorm}, {63'b0, dn});
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, "_idle_ready"}, {63'b0, in_ready}, 64'd1);
        check_eq({tag, "_idle_valid"}, {63'b0, out_valid}, 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"},  {63'b0, out_valid}, 64'd0);
        check_eq({tag, "_sign"},   {63'b0, out_sign}, 64'd0);
        check_eq({tag, "_mag"},    64'(out_mag), 64'd0);
        check_eq({tag, "_exp"},    64'(out_exp), 64'd0);
        check_eq({tag, "_zero"},   {63'b0, out_zero}, 64'd0);
        check_eq({tag, "_denorm"}, {63'b0, out_denorm}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        in_exp    = '0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("post_reset_ready", {63'b0, in_ready}, 64'd1);
        check_eq("post_reset_valid", {63'b0, out_valid}, 64'd0);

        // -1: magnitude 1, 48 shifts, exponent 100-48
        send(49'h1_FFFF_FFFF_FFFF, 10'd100, lat);
        check_result("neg_one", 1'b1, 49'h1_0000_0000_0000, 10'd52, 1'b0, 1'b0, lat, 50);
        release_out("neg_one");

        send(49'h1_0000_0000_0000, 10'd7, lat);
        check_result("most_neg", 1'b1, 49'h1_0000_0000_0000, 10'd7, 1'b0, 1'b0, lat, 2);
        release_out("most_neg");

        send(49'h0, 10'd200, lat);
        check_result("zero", 1'b0, 49'h0, 10'd0, 1'b1, 1'b0, lat, 2);
        // Asynchronous reset while a zero result is parked in DONE
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_in_done");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_done_release_ready", {63'b0, in_ready}, 64'd1);

        send(49'd5, 10'd3, lat);
        check_result("exp_floor", 1'b0, 49'd40, 10'd0, 1'b0, 1'b1, lat, 5);
        release_out("exp_floor");

        // Word A = -3: held under backpressure with in_valid junk that must be ignored
        send(-49'sd3, 10'd60, lat);
        check_result("word_a", 1'b1, 49'h1_8000_0000_0000, 10'd13, 1'b0, 1'b0, lat, 49);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = {17'h0, $urandom()};
            in_exp   = 10'($urandom_range(0, 1023));
            check_eq("bp_valid", {63'b0, out_valid}, 64'd1);
            check_eq("bp_in_ready", {63'b0, in_ready}, 64'd0);
            check_eq("bp_mag", 64'(out_mag), 64'h1_8000_0000_0000);
            check_eq("bp_exp", 64'(out_exp), 64'd13);
            check_eq("bp_sign", {63'b0, out_sign}, 64'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        release_out("word_a");

        send(49'h0_8000_0000_0000, 10'd10, lat);
        check_result("word_b", 1'b0, 49'h1_0000_0000_0000, 10'd9, 1'b0, 1'b0, lat, 3);
        release_out("word_b");

        // Asynchronous reset mid-normalization discards the word
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 49'h1_FFFF_FFFF_FFFF;
        in_exp   = 10'd100;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_in_norm");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_norm_release_ready", {63'b0, in_ready}, 64'd1);
        check_eq("rst_norm_release_valid", {63'b0, out_valid}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_norm_no_result", {63'b0, out_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
